// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, ALU operation
// codes, ALU-op classes and datapath mux selects.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] SRCA_RS1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_OLDPC  = 2'b10;
  localparam logic [1:0] SRCA_ZERO   = 2'b11;

  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU operation decoder: fixed ADD/SUB or funct3/funct7-driven selection.
module alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opb5,
  output logic [3:0] alucontrol
);

  // Map the requested ALU-op class and function fields to an ALU code.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b011:  alucontrol = ALU_SLTU;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          default: alucontrol = ALU_AND;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 subset controller: sequences fetch/decode/execute states
// and drives datapath strobes, memory requests and a retired-instruction count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        memreq,
  output logic        memwrite,
  output logic        adrsrc,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        regwrite,
  output logic        linkwrite,
  output logic [1:0]  alusrcA,
  output logic [1:0]  alusrcB,
  output logic [1:0]  resultsrc,
  output logic [3:0]  alucontrol,
  output logic        hlt,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR,
    EXECI, ALUWB, BRANCH, JUMP, JALR, LUI, HALT
  } state_t;

  state_t      state, state_n;
  logic        jalr_step, jalr_step_n;
  logic [31:0] instret_q;
  logic        hlt_q;
  logic [1:0]  aluop;
  logic [3:0]  alu_code;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .opb5       (opcode[5]),
    .alucontrol (alu_code)
  );

  // Per-state strobes and next state. FETCH, BRANCH strobes depend on the
  // same-cycle mem_ready/zero, so outputs are decoded from state here and
  // forced to zero combinationally while reset is high.
  always_comb begin
    state_n     = state;
    jalr_step_n = jalr_step;
    memreq      = 1'b0;
    memwrite    = 1'b0;
    adrsrc      = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    regwrite    = 1'b0;
    linkwrite   = 1'b0;
    alusrcA     = SRCA_RS1;
    alusrcB     = SRCB_RS2;
    resultsrc   = RES_ALUOUT;
    aluop       = ALUOP_ADD;
    case (state)
      FETCH: begin
        memreq  = 1'b1;
        alusrcA = SRCA_PC;
        alusrcB = SRCB_FOUR;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcwrite   = 1'b1;
          resultsrc = RES_ALU;
          state_n   = DECODE;
        end
      end
      DECODE: begin
        alusrcA = SRCA_OLDPC;
        alusrcB = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_RTYPE:          state_n = EXECR;
          OP_ITYPE:          state_n = EXECI;
          OP_BRANCH:         state_n = BRANCH;
          OP_JAL:            state_n = JUMP;
          OP_JALR:           state_n = JALR;
          OP_LUI:            state_n = LUI;
          default:           state_n = HALT;
        endcase
      end
      MEMADR: begin
        alusrcB = SRCB_IMM;
        if (funct3 == 3'b010) state_n = opcode[5] ? MEMWR : MEMRD;
        else                  state_n = HALT;
      end
      MEMRD: begin
        memreq = 1'b1;
        adrsrc = 1'b1;
        if (mem_ready) state_n = MEMWB;
      end
      MEMWB: begin
        regwrite  = 1'b1;
        resultsrc = RES_MEMDATA;
        state_n   = FETCH;
      end
      MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        adrsrc   = 1'b1;
        if (mem_ready) state_n = FETCH;
      end
      EXECR: begin
        aluop   = ALUOP_FUNCT;
        state_n = ALUWB;
      end
      EXECI: begin
        alusrcB = SRCB_IMM;
        aluop   = ALUOP_FUNCT;
        state_n = ALUWB;
      end
      ALUWB: begin
        regwrite = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        aluop = ALUOP_SUB;
        if (funct3[2:1] == 2'b00) begin
          pcwrite = zero ^ funct3[0];
          state_n = FETCH;
        end else begin
          state_n = HALT;
        end
      end
      JUMP: begin
        pcwrite   = 1'b1;
        linkwrite = 1'b1;
        state_n   = FETCH;
      end
      JALR: begin
        // First pass latches rs1+imm into ALUOut; second pass commits PC and
        // link together, so the link uses the PC before it is overwritten.
        if (!jalr_step) begin
          alusrcB     = SRCB_IMM;
          jalr_step_n = 1'b1;
        end else begin
          pcwrite     = 1'b1;
          linkwrite   = 1'b1;
          jalr_step_n = 1'b0;
          state_n     = FETCH;
        end
      end
      LUI: begin
        alusrcA   = SRCA_ZERO;
        alusrcB   = SRCB_IMM;
        regwrite  = 1'b1;
        resultsrc = RES_ALU;
        state_n   = FETCH;
      end
      HALT: state_n = HALT;
      default: state_n = FETCH;
    endcase
    if (reset) begin
      memreq    = 1'b0;
      memwrite  = 1'b0;
      adrsrc    = 1'b0;
      irwrite   = 1'b0;
      pcwrite   = 1'b0;
      regwrite  = 1'b0;
      linkwrite = 1'b0;
      alusrcA   = '0;
      alusrcB   = '0;
      resultsrc = '0;
    end
  end

  assign alucontrol = reset ? '0 : alu_code;
  assign hlt        = hlt_q & ~reset;
  assign instret    = reset ? '0 : instret_q;

  // State, JALR sub-step, sticky halt and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      jalr_step <= 1'b0;
      instret_q <= '0;
      hlt_q     <= 1'b0;
    end else begin
      state     <= state_n;
      jalr_step <= jalr_step_n;
      if (state != FETCH && state_n == FETCH) instret_q <= instret_q + 32'd1;
      if (state_n == HALT) hlt_q <= 1'b1;
    end
  end

endmodule
